// File: rtl/fifo_af_pkg.sv
// Shared types and constants for the almost_full-driven FIFO writer.
package fifo_af_pkg;

  typedef enum logic [1:0] {
    ST_SEND   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RESUME = 2'd2
  } af_state_e;

  // Writes that can still land after the FIFO fill level crosses its
  // threshold: fill_level reg, almost_full reg, out_valid reg.
  localparam int AF_INFLIGHT_MAX = 3;

  localparam int RESUME_DELAY_DEFAULT = 4;

  function automatic int resume_cnt_w(input int delay);
    int w;
    w = $clog2(delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int RESUME_CNT_W = resume_cnt_w(RESUME_DELAY_DEFAULT);

endpackage

// File: rtl/fifo_af_writer_skid.sv
// Two-entry input buffer with a registered ready derived from next-state occupancy.
module skid_buffer_2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         ready_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q, count_d;
  logic         ready_q;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // On a full buffer push and pop hit the same slot; the head is read
  // before the edge, so the slot can be refilled in the same cycle.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/fifo_af_writer.sv
// Producer endpoint for an almost_full-only FIFO: valid/ready in, write strobes out.
// Optional statistics counters are built when FIFO_AF_WRITER_STATS_EN is defined.
module fifo_af_writer
  import fifo_af_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int RESUME_DELAY = RESUME_DELAY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  almost_full,
  output logic [31:0]           sent_count,
  output logic [31:0]           stall_cycles
);

  localparam int             CW     = resume_cnt_w(RESUME_DELAY);
  localparam logic [CW-1:0]  RELOAD = CW'(RESUME_DELAY);
  localparam logic [CW-1:0]  ONE    = CW'(1);

  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;
  logic [1:0]            buf_cnt;

  af_state_e             state_q, state_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  assign push = in_valid & in_ready;

  skid_buffer_2 #(.W(DATA_WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (in_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (buf_cnt),
    .ready_o (in_ready)
  );

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    case (state_q)
      ST_SEND: begin
        if (almost_full) begin
          state_d = ST_HOLD;
        end else if (buf_cnt != 2'd0) begin
          out_valid_d = 1'b1;
          out_data_d  = head;
          pop         = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!almost_full) begin
          if (RESUME_DELAY == 0) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_RESUME;
            rcnt_d  = RELOAD;
          end
        end
      end
      ST_RESUME: begin
        // Any high sample sends us back to HOLD; the reload happens on re-entry.
        if (almost_full) begin
          state_d = ST_HOLD;
        end else if (rcnt_q <= ONE) begin
          state_d = ST_SEND;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q - ONE;
        end
      end
      default: state_d = ST_SEND;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEND;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef FIFO_AF_WRITER_STATS_EN
  logic [31:0] sent_q, stall_q;
  logic        stalled;

  assign stalled = ((state_q == ST_HOLD) || (state_q == ST_RESUME)) && (buf_cnt != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid_q) sent_q  <= sent_q + 32'd1;
      if (stalled)     stall_q <= stall_q + 32'd1;
    end
  end

  assign sent_count   = sent_q;
  assign stall_cycles = stall_q;
`else
  assign sent_count   = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fifo_af_writer.sv
// Directed bench for fifo_af_writer: streaming, backpressure, hysteresis, model FIFO, reset.
module tb_fifo_af_writer;

  localparam int DW = 512;
`ifdef FIFO_AF_WRITER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          almost_full = 1'b0;
  logic [31:0]   sent_count, stall_cycles;

  int tests = 0;
  int fails = 0;

  bit            af_pat [0:511];
  bit            ov_tr  [0:511];
  bit            ir_tr  [0:511];
  logic [DW-1:0] got[$];
  int            max_occ;
  bit            ovf;

  fifo_af_writer #(.DATA_WIDTH(DW), .RESUME_DELAY(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .almost_full  (almost_full),
    .sent_count   (sent_count),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; almost_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got.delete();
    for (int i = 0; i < 512; i++) begin af_pat[i] = 1'b0; ov_tr[i] = 1'b0; ir_tr[i] = 1'b0; end
  endtask

  // Stream beats base..base+n-1; edge k after the call sees almost_full = af_pat[k]
  // or, with use_model, the registered almost_full of a 16-deep model FIFO.
  task automatic stream(input int n, input int base, input int max_cyc, input bit use_model);
    int  nxt, fill;
    bit  will_acc, af_reg, af_new, prev_ov, rd;
    nxt = 0; fill = 0; af_reg = 0; prev_ov = 0;
    max_occ = 0; ovf = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      almost_full = use_model ? af_reg : af_pat[k];
      in_valid    = (nxt < n);
      in_data     = DW'(base + nxt);
      will_acc    = in_valid && in_ready;
      @(negedge clk);
      if (will_acc) nxt++;
      ov_tr[k] = out_valid;
      ir_tr[k] = in_ready;
      if (out_valid) got.push_back(out_data);
      if (use_model) begin
        af_new = (fill >= 13);
        rd     = ((k % 3) == 0) && (fill > 0);
        fill   = fill + int'(prev_ov) - int'(rd);
        if (fill > 16) ovf = 1'b1;
        if (fill > max_occ) max_occ = fill;
        af_reg  = af_new;
        prev_ov = out_valid;
      end
    end
    in_valid = 1'b0;
    almost_full = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
    tests++; if (sent_count !== 32'd0 || stall_cycles !== 32'd0) begin
      fails++; $display("FAIL rst_counters sent=%0d stall=%0d exp=0/0", sent_count, stall_cycles);
    end
    reset_dut();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_release_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ready_first_clock got=%b exp=1", in_ready); end
  endtask

  task automatic test_stream();
    int bad;
    reset_dut();
    stream(10, 0, 20, 0);
    tests++; if (ir_tr[1] !== 1'b1) begin fails++; $display("FAIL s1_ready got=%b exp=1", ir_tr[1]); end
    tests++; if (ov_tr[2] !== 1'b0 || ov_tr[3] !== 1'b1) begin
      fails++; $display("FAIL s1_latency ov2=%b ov3=%b exp=0/1", ov_tr[2], ov_tr[3]);
    end
    bad = 0;
    for (int k = 3; k <= 12; k++) if (ov_tr[k] !== 1'b1) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL s1_throughput gaps=%0d exp=0", bad); end
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i)) bad++;
    tests++; if (got.size() != 10 || bad != 0) begin
      fails++; $display("FAIL s1_data n=%0d bad=%0d exp=10/0", got.size(), bad);
    end
    tests++; if (sent_count !== 32'(10 * STATS) || stall_cycles !== 32'd0) begin
      fails++; $display("FAIL s1_stats sent=%0d stall=%0d exp=%0d/0", sent_count, stall_cycles, 10 * STATS);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    reset_dut();
    for (int k = 20; k <= 25; k++) af_pat[k] = 1'b1;
    stream(40, 0, 70, 0);
    tests++; if (ov_tr[19] !== 1'b1) begin fails++; $display("FAIL bp_pre_ov got=%b exp=1", ov_tr[19]); end
    bad = 0;
    for (int k = 20; k <= 30; k++) if (ov_tr[k] !== 1'b0) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_hold_writes got=%0d exp=0", bad); end
    tests++; if (ov_tr[31] !== 1'b1) begin fails++; $display("FAIL bp_resume_ov got=%b exp=1", ov_tr[31]); end
    tests++; if (ir_tr[19] !== 1'b1 || ir_tr[20] !== 1'b0 || ir_tr[30] !== 1'b0 || ir_tr[31] !== 1'b1) begin
      fails++; $display("FAIL bp_in_ready r19=%b r20=%b r30=%b r31=%b exp=1/0/0/1", ir_tr[19], ir_tr[20], ir_tr[30], ir_tr[31]);
    end
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i)) bad++;
    tests++; if (got.size() != 40 || bad != 0) begin
      fails++; $display("FAIL bp_data n=%0d bad=%0d exp=40/0", got.size(), bad);
    end
    tests++; if (stall_cycles !== 32'(10 * STATS) || sent_count !== 32'(40 * STATS)) begin
      fails++; $display("FAIL bp_stats stall=%0d sent=%0d exp=%0d/%0d", stall_cycles, sent_count, 10 * STATS, 40 * STATS);
    end
  endtask

  task automatic test_glitch();
    int bad;
    reset_dut();
    af_pat[10] = 1'b1;
    af_pat[13] = 1'b1;
    stream(30, 0, 50, 0);
    tests++; if (ov_tr[9] !== 1'b1) begin fails++; $display("FAIL gl_pre_ov got=%b exp=1", ov_tr[9]); end
    bad = 0;
    for (int k = 10; k <= 18; k++) if (ov_tr[k] !== 1'b0) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL gl_restart writes=%0d exp=0", bad); end
    tests++; if (ov_tr[19] !== 1'b1) begin fails++; $display("FAIL gl_resume_ov got=%b exp=1", ov_tr[19]); end
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i)) bad++;
    tests++; if (got.size() != 30 || bad != 0) begin
      fails++; $display("FAIL gl_data n=%0d bad=%0d exp=30/0", got.size(), bad);
    end
    tests++; if (stall_cycles !== 32'(8 * STATS)) begin
      fails++; $display("FAIL gl_stall got=%0d exp=%0d", stall_cycles, 8 * STATS);
    end
  endtask

  task automatic test_model_fifo();
    int bad;
    reset_dut();
    stream(60, 0, 400, 1);
    tests++; if (ovf !== 1'b0 || max_occ > 16) begin
      fails++; $display("FAIL mf_overflow ovf=%b max_occ=%0d exp=0/<=16", ovf, max_occ);
    end
    tests++; if (max_occ < 13) begin fails++; $display("FAIL mf_pressure max_occ=%0d exp>=13", max_occ); end
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== DW'(i)) bad++;
    tests++; if (got.size() != 60 || bad != 0) begin
      fails++; $display("FAIL mf_data n=%0d bad=%0d exp=60/0", got.size(), bad);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    stream(50, 0, 8, 0);
    in_valid = 1'b1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rm_pre_ov got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL rm_async ov=%b ir=%b exp=0/0", out_valid, in_ready);
    end
    tests++; if (sent_count !== 32'd0 || stall_cycles !== 32'd0) begin
      fails++; $display("FAIL rm_counters sent=%0d stall=%0d exp=0/0", sent_count, stall_cycles);
    end
    in_valid = 1'b0;
    reset_dut();
    stream(3, 100, 10, 0);
    tests++; if (got.size() != 3 || got[0] !== DW'(100) || got[2] !== DW'(102)) begin
      fails++; $display("FAIL rm_first_beat n=%0d first=%0d exp=3/100", got.size(), (got.size() > 0) ? int'(got[0]) : -1);
    end
    tests++; if (sent_count !== 32'(3 * STATS)) begin
      fails++; $display("FAIL rm_sent got=%0d exp=%0d", sent_count, 3 * STATS);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_glitch();
    test_model_fifo();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
